polyphase_combiner: RTL and testbench

POLYPHASE_COMBINER -- requirements
Module: polyphase_combiner

---
 rtl/poly_pkg.sv | 17 +
 rtl/poly_out_fifo.sv | 50 +++++
 rtl/polyphase_combiner.sv | 106 ++++++++++
 tb/tb_polyphase_combiner.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// Shared definitions for the polyphase combiner: default phase count,
// accumulator sizing and the combiner FSM state type.
package poly_pkg;

  localparam int NUM_PHASES_DEF = 4;

  typedef enum logic [0:0] {
    WAIT0 = 1'b0,
    ACCUM = 1'b1
  } comb_state_e;

  // Growth of clog2(phases) bits keeps the phase sum exact
  function automatic int acc_w(input int width_in, input int num_phases);
    return width_in + $clog2(num_phases);
  endfunction

endpackage

// File: rtl/poly_out_fifo.sv
// Output FIFO for combined samples; head entry is always presented on dout.
module poly_out_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0]               r_wr;
  logic [AW-1:0]               r_rd;
  logic [AW:0]                 r_cnt;
  logic                        w_push;
  logic                        w_pop;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign dout   = r_mem[r_rd];
  assign w_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= din;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/polyphase_combiner.sv
// Sums NUM_PHASES polyphase branch results into one output sample and queues
// it in an output FIFO. Define POLY_COMBINE_SAT_EN to saturate instead of wrap.
module polyphase_combiner
  import poly_pkg::*;
#(
  parameter int WIDTH_IN   = 18,
  parameter int WIDTH_OUT  = 16,
  parameter int NUM_PHASES = NUM_PHASES_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          strobe_dataIn,
  input  logic signed [WIDTH_IN-1:0]    dataIn,
  input  logic                          phase_sync,
  output logic signed [WIDTH_OUT-1:0]   dataOut,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic                          overflow,
  output logic [$clog2(NUM_PHASES)-1:0] phase_idx
);
  localparam int ACC_W = acc_w(WIDTH_IN, NUM_PHASES);
  localparam int PH_W  = $clog2(NUM_PHASES);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  comb_state_e                r_state;
  logic signed [ACC_W-1:0]    r_acc;
  logic [PH_W-1:0]            r_phase;
  logic                       r_ovf;

  logic signed [ACC_W-1:0]    w_din_ext;
  logic signed [ACC_W-1:0]    w_sum;
  logic [WIDTH_OUT-1:0]       w_conv;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_full;
  logic                       w_empty;
  logic [CW-1:0]              w_count;
  logic [WIDTH_OUT-1:0]       w_dout;

  assign w_din_ext = {{(ACC_W-WIDTH_IN){dataIn[WIDTH_IN-1]}}, dataIn};
  assign w_sum     = r_acc + w_din_ext;

`ifdef POLY_COMBINE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(WIDTH_OUT-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  always_comb begin
    w_conv = w_sum[WIDTH_OUT-1:0];
    if (w_sum > SAT_MAX)      w_conv = SAT_MAX[WIDTH_OUT-1:0];
    else if (w_sum < SAT_MIN) w_conv = SAT_MIN[WIDTH_OUT-1:0];
  end
`else
  assign w_conv = w_sum[WIDTH_OUT-1:0];
`endif

  // Final phase of a group completes the sum; phase_sync always restarts
  assign w_push = strobe_dataIn && !phase_sync && (r_state == ACCUM) &&
                  (r_phase == PH_W'(NUM_PHASES-1));
  assign w_pop  = ready_in && !w_empty;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state <= WAIT0;
      r_acc   <= '0;
      r_phase <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (strobe_dataIn) begin
        if (phase_sync || r_state == WAIT0) begin
          r_acc   <= w_din_ext;
          r_phase <= PH_W'(1);
          r_state <= ACCUM;
        end else if (w_push) begin
          r_acc   <= '0;
          r_phase <= '0;
          r_state <= WAIT0;
        end else begin
          r_acc   <= w_sum;
          r_phase <= r_phase + PH_W'(1);
        end
      end
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  poly_out_fifo #(
    .WIDTH (WIDTH_OUT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .push  (w_push),
    .din   (w_conv),
    .pop   (w_pop),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign dataOut   = w_dout;
  assign valid_out = (w_count != '0);
  assign overflow  = r_ovf;
  assign phase_idx = r_phase;

endmodule

// File: tb/tb_polyphase_combiner.sv
// Directed self-checking bench for polyphase_combiner (default parameters).
module tb_polyphase_combiner;
  logic               clk_in = 1'b0;
  logic               rst_n_in;
  logic               strobe_dataIn;
  logic signed [17:0] dataIn;
  logic               phase_sync;
  logic signed [15:0] dataOut;
  logic               valid_out;
  logic               ready_in;
  logic               overflow;
  logic [1:0]         phase_idx;

  int n_pass = 0;
  int n_tot  = 0;

  polyphase_combiner dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .strobe_dataIn (strobe_dataIn),
    .dataIn        (dataIn),
    .phase_sync    (phase_sync),
    .dataOut       (dataOut),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .overflow      (overflow),
    .phase_idx     (phase_idx)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic strobe(input int d, input logic sync);
    strobe_dataIn = 1'b1;
    dataIn        = 18'(d);
    phase_sync    = sync;
    @(negedge clk_in);
    strobe_dataIn = 1'b0;
    phase_sync    = 1'b0;
  endtask

  task automatic group(input int a, input int b, input int c, input int d);
    strobe(a, 1'b0); strobe(b, 1'b0); strobe(c, 1'b0); strobe(d, 1'b0);
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  initial begin
    rst_n_in = 1'b0; strobe_dataIn = 1'b0; dataIn = '0;
    phase_sync = 1'b0; ready_in = 1'b1;
    @(negedge clk_in);
    // strobe during reset must be ignored
    strobe_dataIn = 1'b1; dataIn = 18'(99);
    @(negedge clk_in);
    strobe_dataIn = 1'b0;
    rst_n_in = 1'b1;
    chk("rst_valid", valid_out, 0);
    chk("rst_data", dataOut, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_phase", phase_idx, 0);

    // basic 1,2,3,4 with phase_sync on first strobe ignored-as-phase-0
    strobe(1, 1'b0);
    chk("ph_after1", phase_idx, 1);
    strobe(2, 1'b0); strobe(3, 1'b0);
    chk("ph_after3", phase_idx, 3);
    chk("no_out_mid", valid_out, 0);
    strobe(4, 1'b0);
    chk("sum10_valid", valid_out, 1);
    chk("sum10_data", dataOut, 10);
    chk("ph_wrap", phase_idx, 0);
    @(negedge clk_in);
    chk("sum10_popped", valid_out, 0);

    // large positive: wraps to -4, saturates to 32767
    group(131071, 131071, 131071, 131071);
`ifdef POLY_COMBINE_SAT_EN
    chk("pos_conv", dataOut, 32767);
`else
    chk("pos_conv", dataOut, -4);
`endif
    @(negedge clk_in);

    // large negative: -400000 wraps to -6784, saturates to -32768
    group(-100000, -100000, -100000, -100000);
`ifdef POLY_COMBINE_SAT_EN
    chk("neg_conv", dataOut, -32768);
`else
    chk("neg_conv", dataOut, -6784);
`endif
    @(negedge clk_in);

    group(-1, -2, -3, -4);
    chk("neg_small", dataOut, -10);
    @(negedge clk_in);

    // overflow: five groups with no downstream
    ready_in = 1'b0;
    for (int g = 0; g < 4; g++) group(1, 1, 1, 1);
    chk("full_no_ovf", overflow, 0);
    group(1, 1, 1, 1);
    chk("ovf_set", overflow, 1);
    ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", valid_out, 1);
      chk("drain_data", dataOut, 4);
      @(negedge clk_in);
    end
    chk("drain_done", valid_out, 0);
    chk("ovf_sticky", overflow, 1);

    // reset mid-group discards partial sum
    strobe(7, 1'b0); strobe(7, 1'b0); strobe(7, 1'b0);
    do_reset();
    chk("rst_mid_phase", phase_idx, 0);
    chk("rst_mid_ovf", overflow, 0);
    chk("rst_mid_valid", valid_out, 0);
    group(1, 2, 3, 4);
    chk("post_rst_data", dataOut, 10);
    chk("post_rst_valid", valid_out, 1);
    @(negedge clk_in);
    chk("post_rst_single", valid_out, 0);

    // phase_sync restart discards 5,5
    strobe(5, 1'b0); strobe(5, 1'b0);
    strobe(1, 1'b1);
    chk("sync_phase", phase_idx, 1);
    strobe(2, 1'b0); strobe(3, 1'b0);
    chk("sync_no_out", valid_out, 0);
    strobe(4, 1'b0);
    chk("sync_data", dataOut, 10);
    @(negedge clk_in);
    chk("sync_single", valid_out, 0);

    // full FIFO with simultaneous push/pop: no drop, order kept
    ready_in = 1'b0;
    group(2, 2, 2, 2); group(3, 3, 3, 3); group(4, 4, 4, 4); group(5, 5, 5, 5);
    strobe(6, 1'b0); strobe(6, 1'b0); strobe(6, 1'b0);
    chk("pp_head", dataOut, 8);
    ready_in = 1'b1;
    strobe(6, 1'b0);
    chk("pp_no_ovf", overflow, 0);
    chk("pp_order0", dataOut, 12);
    @(negedge clk_in);
    chk("pp_order1", dataOut, 16);
    @(negedge clk_in);
    chk("pp_order2", dataOut, 20);
    @(negedge clk_in);
    chk("pp_order3", dataOut, 24);
    chk("pp_valid3", valid_out, 1);
    @(negedge clk_in);
    chk("pp_empty", valid_out, 0);
    chk("pp_ovf_end", overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
